// File: rtl/mdu_seq.sv
// Iterative shift-add 32x32 unsigned multiplier with HI/LO registers and EX-stage stall request.
// Optional macro MDU_EARLY_DONE_EN: finish as soon as the remaining multiplier bits are all zero.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flushE,
    input  logic             start_mul,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mf_hi_loE,
    input  logic             hi_loE,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hilo_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    logic               go;
    logic               last;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier_next;

    assign go          = start_mul & ~flushE;
    assign acc_next    = mplier[0] ? acc + mcand : acc;
    assign mplier_next = mplier >> 1;

`ifdef MDU_EARLY_DONE_EN
    assign last = (cnt == CW'(WIDTH - 1)) | (mplier_next == '0);
`else
    assign last = (cnt == CW'(WIDTH - 1));
`endif

    assign busy      = (state == RUN);
    // A bubble in EX never needs to wait, even while the multiplier is running.
    assign stall_req = busy & ~flushE & (start_mul | mf_hi_loE);
    assign hilo_out  = hi_loE ? hi : lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, op_a};
                        mplier <= op_b;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        hi    <= acc_next[2*WIDTH-1:WIDTH];
                        lo    <= acc_next[WIDTH-1:0];
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Randomized scoreboard bench for mdu_seq: products and busy lengths come from plain arithmetic.
module tb_mdu_seq;

    logic        clk;
    logic        rst_n;
    logic        flushE;
    logic        start_mul;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mf_hi_loE;
    logic        hi_loE;
    logic        busy;
    logic        stall_req;
    logic [31:0] hilo_out;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flushE    (flushE),
        .start_mul (start_mul),
        .op_a      (op_a),
        .op_b      (op_b),
        .mf_hi_loE (mf_hi_loE),
        .hi_loE    (hi_loE),
        .busy      (busy),
        .stall_req (stall_req),
        .hilo_out  (hilo_out),
        .hi        (hi),
        .lo        (lo)
    );

    typedef struct {
        logic [63:0] prod;
        int          dur;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] model_prod = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Cycles of busy: full width, or (early-done) index of top set bit of op_b plus one, minimum one.
    function automatic int exp_dur(input logic [31:0] b);
`ifdef MDU_EARLY_DONE_EN
        int h;
        h = 1;
        for (int i = 0; i < 32; i++) if (b[i]) h = i + 1;
        return h;
`else
        return 32;
`endif
    endfunction

    // Monitor: every falling edge of busy outside reset is a commit checked against the queue.
    initial begin
        bit prev_busy;
        int busy_cnt;
        exp_t e;
        prev_busy = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
                busy_cnt  = 0;
            end else begin
                if (busy) busy_cnt++;
                if (prev_busy && !busy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_commit", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("commit_hilo", {hi, lo}, e.prod);
                        check("busy_cycles", 64'(busy_cnt), 64'(e.dur));
                    end
                    busy_cnt = 0;
                end
                prev_busy = busy;
            end
        end
    end

    // Present a multiply; while busy it must be stalled, and it is accepted on the first idle edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   guard;
        start_mul = 1'b1;
        op_a      = a;
        op_b      = b;
        guard     = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            check("stall_while_busy", 64'(stall_req), 64'd1);
            guard++;
            if (guard > 200) begin
                check("issue_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk);
        e.prod = 64'(a) * 64'(b);
        e.dur  = exp_dur(b);
        exp_q.push_back(e);
        model_prod = e.prod;
        #1;
        start_mul = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                check("idle_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          guard;

        rst_n = 1'b0; flushE = 1'b0; start_mul = 1'b0;
        op_a = '0; op_b = '0; mf_hi_loE = 1'b0; hi_loE = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        check("rst_hilo_out", 64'(hilo_out), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Maximum product
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        check("max_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        check("max_lo", 64'(lo), 64'h0000_0000_0000_0001);
        hi_loE = 1'b1; #1;
        check("max_hilo_out_hi", 64'(hilo_out), 64'h0000_0000_FFFF_FFFE);
        hi_loE = 1'b0; #1;
        check("max_hilo_out_lo", 64'(hilo_out), 64'h0000_0000_0000_0001);

        // Dependent mfhi arriving 5 cycles after accept
        a = $urandom; b = $urandom | 32'h8000_0000;
        issue(a, b);
        repeat (4) @(posedge clk);
        #1 mf_hi_loE = 1'b1; hi_loE = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            check("mf_stall", 64'(stall_req), 64'd1);
            guard++;
            if (guard > 200) begin check("mf_timeout", 64'd1, 64'd0); break; end
        end
        check("mf_stall_drop", 64'(stall_req), 64'd0);
        check("mf_read_hi", 64'(hilo_out), 64'(model_prod[63:32]));
        @(posedge clk);
        #1 mf_hi_loE = 1'b0;

        // Back-to-back: 7x6 issued while busy
        issue(32'h1234, 32'h5678);
        repeat (3) @(posedge clk);
        #1;
        issue(32'd7, 32'd6);
        wait_idle();
        check("b2b_lo", 64'(lo), 64'h2A);
        check("b2b_hi", 64'(hi), 64'h0);

        // Flush: does not cancel a running multiply and never starts a new one
        issue(32'hDEAD_BEEF, 32'h0000_1357);
        @(posedge clk);
        #1 flushE = 1'b1; start_mul = 1'b1; mf_hi_loE = 1'b1;
        @(negedge clk);
        check("flush_no_stall", 64'(stall_req), 64'd0);
        wait_idle();
        repeat (3) begin
            @(negedge clk);
            check("flush_no_accept", 64'(busy), 64'd0);
        end
        @(posedge clk);
        #1 flushE = 1'b0; start_mul = 1'b0; mf_hi_loE = 1'b0;

        // Reset pulsed mid-run at step 10
        issue(32'h1234, 32'h5678);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        model_prod = '0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("midrst_no_commit", {hi, lo}, 64'd0);
        check("midrst_idle", 64'(busy), 64'd0);

        // Early-done corner: 5x3
        @(posedge clk);
        #1;
        issue(32'd5, 32'd3);
        wait_idle();
        check("early_lo", 64'(lo), 64'd15);

        // Randomized multiplies with idle reads in between
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            issue(a, b);
            if ($urandom_range(0, 1) == 1) wait_idle();
            else repeat ($urandom_range(0, 40)) @(posedge clk);
            #1;
            if (!busy) begin
                mf_hi_loE = 1'b1;
                hi_loE    = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("idle_mf_stall", 64'(stall_req), 64'd0);
                check("idle_mf_read", 64'(hilo_out),
                      64'(hi_loE ? model_prod[63:32] : model_prod[31:0]));
                @(posedge clk);
                #1 mf_hi_loE = 1'b0;
            end
        end
        wait_idle();
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Sequential multiply unit and hi/lo scheduler for the EX stage of the pipelined core. It accepts an unsigned 32x32 multiply from the ID/EX register, runs it as an iterative shift-add over WIDTH cycles, and commits the 64-bit product to the HI/LO registers. Independent instructions keep flowing while it runs. It raises a stall request to the hazard unit when a second multiply or a move-from-HI/LO reaches EX before the result is ready.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flushE  in  1  EX holds a bubble; start_mul and mf_hi_loE are ignored.
- start_mul  in  1  EX holds a multiply instruction.
- op_a  in  WIDTH  multiplicand (forwarded rs value).
- op_b  in  WIDTH  multiplier (forwarded rt value).
- mf_hi_loE  in  1  EX holds mfhi/mflo.
- hi_loE  in  1  read select: 1 = HI, 0 = LO.
- busy  out  1  multiply in progress.
- stall_req  out  1  to hazard unit: freeze F/D/E, insert bubble into M.
- hilo_out  out  WIDTH  selected HI or LO, combinational from the registers.
- hi, lo  out  WIDTH  architectural HI/LO.

## Operation
- FSM has two states, IDLE and RUN. busy = (state == RUN).
- Let go = start_mul & ~flushE.
- **Accept (IDLE):** on a clk edge with go=1:
  - acc = 0, mcand = zero-extended op_a (2·WIDTH bits), mplier = op_b.
  - cnt = 0; state goes to RUN.
- **RUN step (each edge):**
  - If mplier[0], acc += mcand.
  - mcand <<= 1; mplier >>= 1; cnt++.
- **Completion:** on the step edge where cnt reaches WIDTH-1:
  - {hi, lo} <= final acc, i.e. op_a·op_b unsigned, full 2·WIDTH bits.
  - state goes to IDLE.
- **stall_req** = busy & ~flushE & (start_mul | mf_hi_loE). It is combinational.
  - The stalled instruction is held in EX by the hazard unit and retried.
- **Start while busy** is never accepted. Operand registers are loaded only on IDLE accept.
- **Read:** hilo_out = hi_loE ? hi : lo, valid whenever busy=0.
- **flushE during RUN** does not cancel the running multiply. The multiply was already committed to execute.
- **Reset:** rst_n low at any time, including mid-RUN:
  - state = IDLE; cnt, acc, mcand, mplier, hi, lo all 0.
  - busy = 0, stall_req = 0, hilo_out = 0.
  - The in-flight product is discarded and never committed.

## Timing
- Accept on edge E0. busy is high from E0 until edge E_WIDTH.
- HI/LO update at edge E_WIDTH; busy falls at that same edge.
- A dependent mf or multiply stalled in RUN sees stall_req drop in the cycle after E_WIDTH.
  - A stalled mf reads the new hi/lo that cycle.
  - A stalled multiply is accepted on the following edge.
- Back-to-back multiplies: accept-to-accept spacing is WIDTH+1 cycles minimum.
- When idle, an mf in EX never stalls.

## Configuration
- MDU_EARLY_DONE_EN defined:
  - RUN also completes, with commit and return to IDLE, on the step edge where the post-shift mplier is 0.
  - op_b = 0 completes after 1 step.
  - op_b = 3 completes after 2 steps.
- MDU_EARLY_DONE_EN undefined: every multiply takes exactly WIDTH steps, regardless of operands.

## Test plan
- Reset: hold rst_n low 3 cycles -> hi=lo=0, busy=0, stall_req=0, hilo_out=0.
- Max product: start_mul 1 cycle, op_a=op_b=0xFFFFFFFF -> busy high 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
- Dependent read: mfhi (hi_loE=1) held in EX from 5 cycles after accept -> stall_req high until busy falls, then hilo_out equals the new hi.
- Back-to-back:
  - Multiply 7x6 issued while busy with an earlier multiply -> stalled, accepted the cycle after completion.
  - Final result lo=0x0000002A, hi=0.
- Reset mid-run: rst_n pulsed low at step 10 of 0x1234x0x5678 -> IDLE immediately, hi=lo=0, no later commit.
- Early done: op_a=5, op_b=3:
  - With MDU_EARLY_DONE_EN: busy high for 2 cycles, lo=15.
  - Without MDU_EARLY_DONE_EN: busy high for 32 cycles, lo=15.
